config_memory_unit: RTL and testbench

Configuration memory stage directly downstream of the access control unit in the smart-home system. It consumes the 35-bit configuration word and the level-type write enable from the control unit, commits a configuration only after it has been held stable for a programmable number of cycles, and drives the committed configuration to the home devices. It also stores the 2-bit system key returned to the control unit's password check.

---
 rtl/cfgmem_pkg.sv | 23 ++
 rtl/edge_detect_rise.sv | 21 ++
 rtl/config_memory_unit.sv | 137 +++++++++++++
 tb/tb_config_memory_unit.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/cfgmem_pkg.sv
// Shared constants, state encoding and helpers for the configuration memory stage.
package cfgmem_pkg;

  localparam int unsigned CFG_W = 35;
  localparam int unsigned KEY_W = 2;
  localparam logic [7:0] CNT_MAX = 8'hFF;

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StVerify = 3'd1;
  localparam logic [2:0] StCommit = 3'd2;
  localparam logic [2:0] StAbort  = 3'd3;
  localparam logic [2:0] StHold   = 3'd4;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == CNT_MAX) ? v : v + 8'd1;
  endfunction

  // Even parity: the stored bit makes the total count of ones even.
  function automatic logic even_parity(input logic [CFG_W-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/edge_detect_rise.sv
// Registers a level and flags its rising edge (current high, previous low).
module edge_detect_rise (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sig_i,
  output logic rise_o
);

  logic sig_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sig_q <= 1'b0;
    end else begin
      sig_q <= sig_i;
    end
  end

  assign rise_o = sig_i & ~sig_q;

endmodule

// File: rtl/config_memory_unit.sv
// Commits a configuration word once it has been held stable for STABLE_CYCLES cycles.
// Optional macro CFGMEM_PARITY_EN adds a stored parity bit and a parity_err output.
module config_memory_unit
  import cfgmem_pkg::*;
#(
  parameter int unsigned      STABLE_CYCLES = 4,
  parameter logic [CFG_W-1:0] RESET_CONFIG  = '0,
  parameter logic [KEY_W-1:0] RESET_KEY     = '0
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             write_en,
  input  logic [CFG_W-1:0] configin,
  input  logic             key_load,
  input  logic [KEY_W-1:0] key_in,
  output logic [KEY_W-1:0] syskey,
  output logic [CFG_W-1:0] config_active,
  output logic             commit_pulse,
  output logic             abort_pulse,
  output logic [7:0]       write_count,
`ifdef CFGMEM_PARITY_EN
  output logic             parity_err,
`endif
  output logic             busy
);

  localparam int unsigned    CntW    = $clog2(STABLE_CYCLES) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(STABLE_CYCLES - 1);

  logic [2:0]       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [CFG_W-1:0] shadow_q, shadow_d;
  logic [CFG_W-1:0] cfg_q, cfg_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [7:0]       wc_q, wc_d;
  logic             rise;

  edge_detect_rise u_we_edge (
    .clk_i  (clk),
    .rst_ni (arst),
    .sig_i  (write_en),
    .rise_o (rise)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    cfg_d    = cfg_q;
    key_d    = key_q;
    wc_d     = wc_q;
    case (state_q)
      StIdle: begin
        // A rise takes priority and drops a coincident key strobe.
        if (rise) begin
          shadow_d = configin;
          cnt_d    = '0;
          state_d  = StVerify;
        end else if (key_load) begin
          key_d = key_in;
        end
      end
      StVerify: begin
        if (!write_en || (configin != shadow_q)) begin
          state_d = StAbort;
        end else if (cnt_q == CntLast) begin
          cfg_d   = shadow_q;
          state_d = StCommit;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StCommit: begin
        wc_d    = sat_inc(wc_q);
        state_d = StHold;
      end
      StAbort: begin
        state_d = StHold;
      end
      StHold: begin
        if (!write_en) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      shadow_q <= RESET_CONFIG;
      cfg_q    <= RESET_CONFIG;
      key_q    <= RESET_KEY;
      wc_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      cfg_q    <= cfg_d;
      key_q    <= key_d;
      wc_q     <= wc_d;
    end
  end

`ifdef CFGMEM_PARITY_EN
  logic parity_q, parity_d;

  always_comb begin
    parity_d = parity_q;
    if ((state_q == StVerify) && (state_d == StCommit)) begin
      parity_d = even_parity(shadow_q);
    end
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      parity_q <= even_parity(RESET_CONFIG);
    end else begin
      parity_q <= parity_d;
    end
  end

  assign parity_err = (even_parity(cfg_q) != parity_q);
`endif

  assign syskey        = key_q;
  assign config_active = cfg_q;
  assign write_count   = wc_q;
  assign commit_pulse  = (state_q == StCommit);
  assign abort_pulse   = (state_q == StAbort);
  assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_config_memory_unit.sv
// Directed and randomized write transactions checked against a transaction-level model.
module tb_config_memory_unit;
  import cfgmem_pkg::*;

  localparam int unsigned S = 4;

  logic             clk = 1'b0;
  logic             arst = 1'b0;
  logic             write_en = 1'b0;
  logic [CFG_W-1:0] configin = '0;
  logic             key_load = 1'b0;
  logic [KEY_W-1:0] key_in = '0;
  logic [KEY_W-1:0] syskey;
  logic [CFG_W-1:0] config_active;
  logic             commit_pulse;
  logic             abort_pulse;
  logic [7:0]       write_count;
  logic             busy;
`ifdef CFGMEM_PARITY_EN
  logic             parity_err;
`endif

  config_memory_unit #(
    .STABLE_CYCLES (S),
    .RESET_CONFIG  ('0),
    .RESET_KEY     ('0)
  ) dut (
    .clk           (clk),
    .arst          (arst),
    .write_en      (write_en),
    .configin      (configin),
    .key_load      (key_load),
    .key_in        (key_in),
    .syskey        (syskey),
    .config_active (config_active),
    .commit_pulse  (commit_pulse),
    .abort_pulse   (abort_pulse),
    .write_count   (write_count),
`ifdef CFGMEM_PARITY_EN
    .parity_err    (parity_err),
`endif
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [CFG_W-1:0] exp_cfg = '0;
  int               exp_count = 0;
  logic [KEY_W-1:0] exp_key = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One write: rise at E0, optional disturbance sampled at edge d (kind 0 = word change,
  // kind 1 = write_en drop), write_en otherwise held for S+4 edges, then released.
  task automatic do_write(input logic [CFG_W-1:0] w, input int d, input int kind,
                          input bit key_with_rise);
    logic [CFG_W-1:0] old_cfg;
    bit               committed;
    int               ncom, nab, com_edge, ab_edge;
    old_cfg   = exp_cfg;
    committed = (d == 0) || (d > int'(S));
    ncom = 0; nab = 0; com_edge = -1; ab_edge = -1;
    write_en = 1'b1;
    configin = w;
    if (key_with_rise) begin
      key_load = 1'b1;
      key_in   = ~exp_key;
    end
    tick();
    key_load = 1'b0;
    check("busy_after_rise", 64'(busy), 64'd1);
    if (key_with_rise) check("key_dropped_on_rise", 64'(syskey), 64'(exp_key));
    for (int e = 1; e <= int'(S) + 4; e++) begin
      if (e == d) begin
        if (kind == 0) configin = w ^ (35'd1 << $urandom_range(0, CFG_W - 1));
        else write_en = 1'b0;
      end
      tick();
      if (commit_pulse) begin ncom++; com_edge = e; end
      if (abort_pulse) begin nab++; ab_edge = e; end
      check("cfg_track", 64'(config_active), 64'((committed && e >= int'(S)) ? w : old_cfg));
    end
    check("commit_cnt", 64'(ncom), committed ? 64'd1 : 64'd0);
    check("abort_cnt", 64'(nab), committed ? 64'd0 : 64'd1);
    if (committed) check("commit_edge", 64'(com_edge), 64'(S));
    else check("abort_edge", 64'(ab_edge), 64'(d));
    if (write_en) check("hold_busy", 64'(busy), 64'd1);
    write_en = 1'b0;
    tick();
    tick();
    check("idle_after_drop", 64'(busy), 64'd0);
    if (committed) begin
      exp_cfg = w;
      if (exp_count < 255) exp_count++;
    end
    check("write_count", 64'(write_count), 64'(exp_count));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [KEY_W-1:0] k;
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_cfg_in_reset", 64'(config_active), 64'd0);
    check("rst_busy_in_reset", 64'(busy), 64'd0);
    @(negedge clk);
    arst = 1'b1;
    tick();
    check("rst_cfg", 64'(config_active), 64'd0);
    check("rst_key", 64'(syskey), 64'd0);
    check("rst_count", 64'(write_count), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_commit", 64'(commit_pulse), 64'd0);
    check("rst_abort", 64'(abort_pulse), 64'd0);

    // Key programming in IDLE
    key_load = 1'b1;
    key_in   = 2'b10;
    tick();
    key_load = 1'b0;
    exp_key  = 2'b10;
    check("key_load", 64'(syskey), 64'(exp_key));
    k = KEY_W'($urandom_range(0, 3));
    key_load = 1'b1;
    key_in   = k;
    tick();
    key_load = 1'b0;
    exp_key  = k;
    check("key_load_rand", 64'(syskey), 64'(exp_key));

    // Directed: clean commit, word change at E2, drop during COMMIT, key strobe with rise
    do_write(35'h1_2345_6789, 0, 0, 1'b0);
    do_write(35'h0_0F0F_F0F0, 2, 0, 1'b0);
    do_write(35'h7_FFFF_0001, int'(S), 1, 1'b0);
    do_write(35'h2_AAAA_5555, int'(S) + 1, 1, 1'b0);
    do_write(35'h3_1357_9BDF, 0, 0, 1'b1);

    // Randomized transactions
    for (int i = 0; i < 30; i++) begin
      do_write({3'($urandom), $urandom}, $urandom_range(0, S + 1), $urandom_range(0, 1),
               1'($urandom_range(0, 1)));
    end

    // Saturation of the commit counter
    while (exp_count < 255) do_write({3'($urandom), $urandom}, 0, 0, 1'b0);
    for (int i = 0; i < 3; i++) do_write({3'($urandom), $urandom}, 0, 0, 1'b0);
    check("count_saturated", 64'(write_count), 64'd255);

    // Reset asserted while in VERIFY
    write_en = 1'b1;
    configin = 35'h5_0505_0505;
    tick();
    tick();
    check("in_verify", 64'(busy), 64'd1);
    #2;
    arst = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_cfg", 64'(config_active), 64'd0);
    check("arst_count", 64'(write_count), 64'd0);
    check("arst_key", 64'(syskey), 64'd0);
    write_en  = 1'b0;
    exp_cfg   = '0;
    exp_count = 0;
    exp_key   = '0;
    @(negedge clk);
    arst = 1'b1;
    tick();
    check("post_arst_idle", 64'(busy), 64'd0);
    do_write(35'h7, 0, 0, 1'b0);

`ifdef CFGMEM_PARITY_EN
    check("parity_ok", 64'(parity_err), 64'd0);
    force dut.cfg_q = 35'h6;
    #1;
    check("parity_err", 64'(parity_err), 64'd1);
    release dut.cfg_q;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
